// File: rtl/div_repsub_ctrl.sv
// Sequential unsigned divider by repeated subtraction.
// FSM controller plus datapath (dividend/remainder A, divisor B, quotient Q).
// Both operands arrive on the shared data_in bus on the two cycles after start.
module div_repsub_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             busy,
    output logic             div_by_zero
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LDA  = 3'd1,
        LDB  = 3'd2,
        CHK  = 3'd3,
        SUB  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [WIDTH-1:0] reg_q;
    logic             dbz;

    logic             b_zero;
    logic             a_ge_b;
    logic [WIDTH-1:0] diff;

    // Status detects and subtractor; diff is only consumed when a_ge_b is set
    always_comb begin
        b_zero = (reg_b == '0);
        a_ge_b = (reg_a >= reg_b);
        diff   = reg_a - reg_b;
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and Moore decode of done/busy
    always_comb begin
        next_state = state;
        done       = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = LDA;
            end
            LDA: begin
                busy       = 1'b1;
                next_state = LDB;
            end
            LDB: begin
                busy       = 1'b1;
                next_state = CHK;
            end
            CHK: begin
                busy       = 1'b1;
                next_state = b_zero ? DONE : SUB;
            end
            SUB: begin
                busy = 1'b1;
                if (!a_ge_b) next_state = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) next_state = LDA;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath registers, updated according to the current state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reg_a <= '0;
            reg_b <= '0;
            reg_q <= '0;
            dbz   <= 1'b0;
        end else begin
            case (state)
                LDA: begin
                    reg_a <= data_in;
                end
                LDB: begin
                    reg_b <= data_in;
                    reg_q <= '0;
                    dbz   <= 1'b0;
                end
                CHK: begin
                    if (b_zero) begin
                        dbz   <= 1'b1;
                        reg_q <= '1;
                    end
                end
                SUB: begin
                    if (a_ge_b) begin
                        reg_a <= diff;
                        reg_q <= reg_q + WIDTH'(1);
                    end
                end
                DONE: begin
                    if (start) dbz <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Outputs come straight from registers
    always_comb begin
        quotient    = reg_q;
        remainder   = reg_a;
        div_by_zero = dbz;
    end

endmodule

// File: tb/tb_div_repsub_ctrl.sv
// Self-checking bench for div_repsub_ctrl: directed cases with literal
// expectations plus randomized operations, all compared every cycle against
// an arithmetic model (a/b, a%b, closed-form intermediate values).
module tb_div_repsub_ctrl;

    localparam int W = 16;

    logic         clock;
    logic         reset_n;
    logic         start;
    logic [W-1:0] data_in;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         done;
    logic         busy;
    logic         div_by_zero;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    div_repsub_ctrl #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .data_in    (data_in),
        .quotient   (quotient),
        .remainder  (remainder),
        .done       (done),
        .busy       (busy),
        .div_by_zero(div_by_zero)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- behavioural model ----------------
    // Tracks the edge index k since the accepted start; results follow from
    // plain division. After edge k>=3 with b!=0, j=min(k-3, a/b) subtractions
    // have happened: Q=j, A=a-j*b.
    logic         m_busy, m_done, m_dbz;
    logic [W-1:0] m_q, m_r, m_a, m_b;
    int unsigned  k, fin;

    function automatic int unsigned steps(input int unsigned kn, input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned j;
        j = kn - 3;
        if (j > a / b) j = a / b;
        return j;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
            m_q <= '0; m_r <= '0; m_a <= '0; m_b <= '0;
            k <= 0; fin <= 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1; m_done <= 1'b0; m_dbz <= 1'b0; k <= 0;
            end
        end else begin
            k <= k + 1;
            if (k + 1 == 1) begin
                m_a <= data_in; m_r <= data_in;
            end else if (k + 1 == 2) begin
                m_b <= data_in; m_q <= '0;
                fin <= (data_in == '0) ? 3 : int'(m_a / data_in) + 4;
            end else begin
                if (m_b == '0) begin
                    m_q <= '1; m_dbz <= 1'b1;
                end else begin
                    m_q <= W'(steps(k + 1, m_a, m_b));
                    m_r <= m_a - W'(steps(k + 1, m_a, m_b)) * m_b;
                end
                if (k + 1 == fin) begin
                    m_busy <= 1'b0; m_done <= 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clock) begin
        if (cmp_en) begin
            checks++;
            if ({busy, done, div_by_zero, quotient, remainder} !==
                {m_busy, m_done, m_dbz, m_q, m_r}) begin
                failures++;
                $display("FAIL cycle_model t=%0t got busy=%b done=%b dbz=%b q=%0d r=%0d expected busy=%b done=%b dbz=%b q=%0d r=%0d",
                         $time, busy, done, div_by_zero, quotient, remainder,
                         m_busy, m_done, m_dbz, m_q, m_r);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one operation from a negedge in IDLE/DONE; optional noise pulses
    // start and toggles data_in while the operation must ignore them.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit noise, input int limit, input int exp_edges,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
        int edges;
        start = 1'b1;
        @(posedge clock);               // E0
        edges = 0;
        @(negedge clock);
        start = 1'b0; data_in = a;
        @(posedge clock); edges++;      // E1
        @(negedge clock);
        data_in = b;
        if (noise) start = 1'b1;
        @(posedge clock); edges++;      // E2
        @(negedge clock);
        start = 1'b0;
        data_in = noise ? W'($urandom) : '0;
        while (1) begin
            @(posedge clock); edges++;
            @(negedge clock);
            if (done || edges >= limit) break;
            if (noise) begin
                start   = 1'($urandom);
                data_in = W'($urandom);
            end
        end
        start = 1'b0;
        check({name, "_edges"}, edges, exp_edges);
        check({name, "_q"}, quotient, eq);
        check({name, "_r"}, remainder, er);
        check({name, "_dbz"}, div_by_zero, edbz);
    endtask

    initial begin
        int edges;
        logic [W-1:0] ra, rb, eq, er;
        start   = 1'b0;
        data_in = '0;
        reset_n = 1'b0;
        #2;
        check("reset_outputs", {busy, done, div_by_zero, quotient, remainder}, '0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        cmp_en  = 1'b1;

        // 1. 100 / 7
        run_op("div100_7", 16'd100, 16'd7, 0, 200, 18, 16'd14, 16'd2, 1'b0);
        check("model_q_100_7", m_q, 14);
        check("model_r_100_7", m_r, 2);

        // 2. dividend < divisor
        run_op("div5_9", 16'd5, 16'd9, 0, 100, 4, 16'd0, 16'd5, 1'b0);

        // 3. worst case and zero dividend
        run_op("divffff_1", 16'hFFFF, 16'd1, 0, 70000, 65539, 16'hFFFF, 16'd0, 1'b0);
        run_op("div0_4", 16'd0, 16'd4, 0, 100, 4, 16'd0, 16'd0, 1'b0);

        // 4. divide by zero, then restart
        run_op("div23_0", 16'd23, 16'd0, 0, 100, 3, 16'hFFFF, 16'd23, 1'b1);
        run_op("div8_2", 16'd8, 16'd2, 0, 100, 8, 16'd4, 16'd0, 1'b0);

        // 5. asynchronous reset mid-SUB, then a clean operation
        start = 1'b1;
        @(negedge clock);
        start = 1'b0; data_in = 16'd1000;
        @(negedge clock);
        data_in = 16'd3;
        repeat (20) @(negedge clock);
        check("mid_sub_busy", busy, 1'b1);
        #2 reset_n = 1'b0;
        #1 check("async_reset_outputs", {busy, done, div_by_zero, quotient, remainder}, '0);
        @(negedge clock);
        reset_n = 1'b1;
        run_op("div42_6", 16'd42, 16'd6, 0, 100, 11, 16'd7, 16'd0, 1'b0);

        // 6. start noise ignored, then start held two cycles in DONE
        run_op("div50_5_noise", 16'd50, 16'd5, 1, 100, 14, 16'd10, 16'd0, 1'b0);
        start = 1'b1;
        @(posedge clock);               // E0
        @(negedge clock);
        data_in = 16'd60;               // start still high in LDA
        @(posedge clock);               // E1
        @(negedge clock);
        start = 1'b0; data_in = 16'd4;
        @(posedge clock);               // E2
        edges = 2;
        while (1) begin
            @(posedge clock); edges++;
            @(negedge clock);
            if (done || edges >= 100) break;
        end
        check("hold_start_edges", edges, 19);
        check("hold_start_q", quotient, 16'd15);
        check("hold_start_r", remainder, 16'd0);
        repeat (3) @(negedge clock);
        check("hold_start_single_op", {done, busy}, 2'b10);

        // Randomized operations with bounded quotients
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                ra = W'($urandom_range(0, 65535));
                rb = '0;
            end else if ($urandom_range(0, 1) == 1) begin
                ra = W'($urandom_range(0, 65535));
                rb = W'($urandom_range(256, 65535));
            end else begin
                ra = W'($urandom_range(0, 400));
                rb = W'($urandom_range(1, 40));
            end
            if (rb == '0) begin
                eq = '1; er = ra;
            end else begin
                eq = ra / rb; er = ra % rb;
            end
            run_op("rand", ra, rb, 1'($urandom), 1000,
                   (rb == '0) ? 3 : int'(eq) + 4, eq, er, rb == '0);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clock);
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
